poly_sound_driver: RTL and testbench
====================================

Name: poly_sound_driver

Overview:
- Multi-voice successor to the single-voice sound driver. Runs VOICES independent phase-accumulator oscillators, each with its own divider, waveform mode and gate.
- Once per sample tick, scales every voice's phase to SAMPLE_W bits using one shared, time-multiplexed restoring divider, then shapes, mixes and averages the voices.
- Drives the mixed sample out as a registered PWM bit-stream. Sits between the keypad/note decoder and the board's audio pin.

Parameters:
- VOICES, 4, number of voices; power of two, ≥1.
- DIV_W, 18, divider/phase counter width.
- SAMPLE_W, 8, sample and PWM resolution in bits.
- SAMPLE_DIV, 256, clk cycles per sample tick; must be ≥ VOICES*(SAMPLE_W+2)+2.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- divider  in  VOICES*DIV_W  per-voice period in clk cycles; voice v uses bits [v*DIV_W +: DIV_W]; 0 = silent.
- mode  in  VOICES*2  per-voice waveform: 00 square, 01 sawtooth, 10 triangle, 11 off.
- gate  in  VOICES  per-voice enable; 0 = voice contributes 0.
- strobe  in  1  PWM duty update enable.
- sample  out  SAMPLE_W  current mixed sample.
- sample_valid  out  1  one-cycle pulse when sample updates.
- busy  out  1  high while the scaler FSM is not IDLE.
- pwm_output  out  1  registered PWM bit.

Behaviour:
- Reset: nrst is asynchronous, active-low; clock is clk. While nrst=0, all phase counters, tick counter, FSM, accumulator, sample, sample_valid, busy, PWM counter, duty and pwm_output are 0.
- Phase counter per voice, every clk:
  - if divider==0, phase←0;
  - else if phase ≥ divider-1, phase←0;
  - else phase←phase+1.
  - If divider shrinks below the current phase, the counter wraps to 0 on the next clk.
- Tick counter counts 0..SAMPLE_DIV-1 and wraps. The tick fires when it is SAMPLE_DIV-1.
- On tick, snapshot all phases, dividers, modes and gates into shadow registers. Later input changes do not affect the conversion in progress.
- Scaler FSM states: IDLE, LOAD, DIVIDE, SHAPE, MIX.
  - IDLE→LOAD on tick, with voice index v=0 and acc=0.
  - LOAD: initialise restoring division of phase_v·2^SAMPLE_W by divider_v. If divider_v==0 or gate_v==0 or mode_v==11, skip to SHAPE with q=0 and contribution forced to 0.
  - DIVIDE: exactly SAMPLE_W cycles, one quotient bit per cycle, MSB first. Result q=floor(phase·2^SAMPLE_W/divider), always < 2^SAMPLE_W.
  - SHAPE (1 cycle), with M=2^SAMPLE_W-1:
    - square: q < 2^(SAMPLE_W-1) ? M : 0.
    - saw: q.
    - triangle: t = q[MSB] ? ~q : q, then w = {t[SAMPLE_W-2:0],0}.
  - SHAPE adds w to acc (width SAMPLE_W+log2(VOICES)). If v<VOICES-1, increment v and go to LOAD; else go to MIX.
  - MIX (1 cycle): sample←acc>>log2(VOICES), sample_valid=1 for that cycle, then return to IDLE.
- busy=1 in every state except IDLE.
- Tick latency to sample_valid is VOICES*(SAMPLE_W+2)+2 cycles worst case.
- A tick arriving while busy cannot occur, given the SAMPLE_DIV constraint. If it does, it is ignored.
- PWM:
  - SAMPLE_W-bit counter free-runs and wraps at M.
  - When the counter==M and strobe==1, duty←sample. With strobe==0, duty holds.
  - pwm_output←(counter<duty), registered, 1-cycle latency.
  - duty=0 gives constant 0. duty=M gives high for M of every 2^SAMPLE_W cycles.
- Reset mid-conversion: FSM returns to IDLE, no sample_valid is produced, and sample stays 0 until the next full conversion.

Test Plan:
- Hold nrst=0 for 10 cycles, then release with all gates=0 → sample=0, sample_valid pulses every 256 cycles, pwm_output stays 0.
- Voice0 saw with divider=1000, other gates=0; check the tick whose phase snapshot is 500 → q=128, sample=32 (128>>2).
- All 4 voices square, phase snapshots < divider/2 → each contributes 255, acc=1020, sample=255. One voice with divider=0 → sample=191.
- strobe=1 with sample=64 → pwm_output high exactly 64 of every 256 cycles. Drop strobe and change sample to 200 → duty stays 64.
- Triangle with q=192 → w=126. mode=11 → contribution 0 regardless of divider.
- Assert nrst during DIVIDE of voice 2 → busy=0, sample=0, no sample_valid; the next conversion completes normally. Separately, reduce divider from 1000 to 100 while phase=700 → phase=0 next cycle.

Source files
------------

// File: rtl/poly_sound_driver.sv
// Polyphonic tone generator: per-voice phase accumulators, one shared restoring
// divider that scales each phase once per sample tick, waveform shaping, mixing and PWM out.
module poly_sound_driver #(
   parameter int VOICES     = 4,
   parameter int DIV_W      = 18,
   parameter int SAMPLE_W   = 8,
   parameter int SAMPLE_DIV = 256
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic [VOICES*DIV_W-1:0]   divider,
   input  logic [VOICES*2-1:0]       mode,
   input  logic [VOICES-1:0]         gate,
   input  logic                      strobe,
   output logic [SAMPLE_W-1:0]       sample,
   output logic                      sample_valid,
   output logic                      busy,
   output logic                      pwm_output
);

   localparam int LOG2V  = $clog2(VOICES);
   localparam int VIDX_W = (VOICES > 1) ? LOG2V : 1;
   localparam int ACC_W  = SAMPLE_W + LOG2V;
   localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int BIT_W  = $clog2(SAMPLE_W + 1);
   localparam logic [SAMPLE_W-1:0] M = '1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIVIDE, S_SHAPE, S_MIX} state_t;

   state_t                          state_q, state_d;
   logic [VOICES-1:0][DIV_W-1:0]    phase_q, phase_d;
   logic [VOICES-1:0][DIV_W-1:0]    div_s_q, div_s_d, phase_s_q, phase_s_d;
   logic [VOICES-1:0][1:0]          mode_s_q, mode_s_d;
   logic [VOICES-1:0]               gate_s_q, gate_s_d;
   logic [TICK_W-1:0]               tick_q, tick_d;
   logic [VIDX_W-1:0]               v_q, v_d;
   logic [ACC_W-1:0]                acc_q, acc_d;
   logic [DIV_W-1:0]                rem_q, rem_d;
   logic [SAMPLE_W-1:0]             q_q, q_d;
   logic [BIT_W-1:0]                bit_q, bit_d;
   logic                            skip_q, skip_d;
   logic [SAMPLE_W-1:0]             sample_q, sample_d;
   logic                            valid_q, valid_d;
   logic [SAMPLE_W-1:0]             pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
   logic                            pwm_q, pwm_d;

   logic                            tick;
   logic [DIV_W-1:0]                cur_div, cur_ph;
   logic [1:0]                      cur_mode;
   logic                            cur_gate;
   logic [DIV_W:0]                  rem_sh;
   logic [SAMPLE_W-1:0]             shape_w, tri_t;

   assign tick     = (tick_q == TICK_W'(SAMPLE_DIV - 1));
   assign cur_div  = div_s_q[v_q];
   assign cur_ph   = phase_s_q[v_q];
   assign cur_mode = mode_s_q[v_q];
   assign cur_gate = gate_s_q[v_q];

   always_comb begin
      tick_d = tick ? '0 : tick_q + TICK_W'(1);
      for (int v = 0; v < VOICES; v++) begin
         if (divider[v*DIV_W +: DIV_W] == '0 ||
             phase_q[v] >= divider[v*DIV_W +: DIV_W] - DIV_W'(1))
            phase_d[v] = '0;
         else
            phase_d[v] = phase_q[v] + DIV_W'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      v_d       = v_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      q_d       = q_q;
      bit_d     = bit_q;
      skip_d    = skip_q;
      sample_d  = sample_q;
      valid_d   = 1'b0;
      div_s_d   = div_s_q;
      phase_s_d = phase_s_q;
      mode_s_d  = mode_s_q;
      gate_s_d  = gate_s_q;
      rem_sh    = {rem_q, 1'b0};
      shape_w   = '0;
      tri_t     = '0;
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d   = S_LOAD;
               v_d       = '0;
               acc_d     = '0;
               div_s_d   = divider;
               phase_s_d = phase_q;
               mode_s_d  = mode;
               gate_s_d  = gate;
            end
         end
         S_LOAD: begin
            skip_d = (cur_div == '0) || !cur_gate || (cur_mode == 2'b11);
            q_d    = '0;
            bit_d  = '0;
            // A phase caught just after the divider shrank is clamped so q stays in range.
            rem_d  = (cur_ph >= cur_div) ? cur_div - DIV_W'(1) : cur_ph;
            state_d = skip_d ? S_SHAPE : S_DIVIDE;
         end
         S_DIVIDE: begin
            if (rem_sh >= {1'b0, cur_div}) begin
               rem_d = DIV_W'(rem_sh - {1'b0, cur_div});
               q_d   = {q_q[SAMPLE_W-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[DIV_W-1:0];
               q_d   = {q_q[SAMPLE_W-2:0], 1'b0};
            end
            bit_d = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(SAMPLE_W - 1))
               state_d = S_SHAPE;
         end
         S_SHAPE: begin
            tri_t = q_q[SAMPLE_W-1] ? ~q_q : q_q;
            case (cur_mode)
               2'b00:   shape_w = q_q[SAMPLE_W-1] ? '0 : M;
               2'b01:   shape_w = q_q;
               2'b10:   shape_w = {tri_t[SAMPLE_W-2:0], 1'b0};
               default: shape_w = '0;
            endcase
            if (skip_q)
               shape_w = '0;
            acc_d = acc_q + ACC_W'(shape_w);
            if (v_q == VIDX_W'(VOICES - 1)) begin
               state_d = S_MIX;
            end else begin
               v_d     = v_q + VIDX_W'(1);
               state_d = S_LOAD;
            end
         end
         S_MIX: begin
            sample_d = SAMPLE_W'(acc_q >> LOG2V);
            valid_d  = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + SAMPLE_W'(1);
      duty_d    = (pwm_cnt_q == M && strobe) ? sample_q : duty_q;
      pwm_d     = (pwm_cnt_q < duty_q);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= S_IDLE;
         phase_q   <= '0;
         div_s_q   <= '0;
         phase_s_q <= '0;
         mode_s_q  <= '0;
         gate_s_q  <= '0;
         tick_q    <= '0;
         v_q       <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         q_q       <= '0;
         bit_q     <= '0;
         skip_q    <= 1'b0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         pwm_cnt_q <= '0;
         duty_q    <= '0;
         pwm_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         div_s_q   <= div_s_d;
         phase_s_q <= phase_s_d;
         mode_s_q  <= mode_s_d;
         gate_s_q  <= gate_s_d;
         tick_q    <= tick_d;
         v_q       <= v_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         q_q       <= q_d;
         bit_q     <= bit_d;
         skip_q    <= skip_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         pwm_cnt_q <= pwm_cnt_d;
         duty_q    <= duty_d;
         pwm_q     <= pwm_d;
      end
   end

   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign busy         = (state_q != S_IDLE);
   assign pwm_output   = pwm_q;

endmodule

// File: tb/tb_poly_sound_driver.sv
// Testbench for poly_sound_driver: behavioural tick/phase model computes each expected
// mixed sample from the snapshot rules; scenario tasks compare DUT outputs against it.
module tb_poly_sound_driver;
   localparam int VOICES = 4;
   localparam int DIV_W  = 18;
   localparam int SW     = 8;
   localparam int SDIV   = 256;
   localparam int MAXLAT = VOICES * (SW + 2) + 2;

   logic                    clk = 1'b0;
   logic                    nrst = 1'b0;
   logic [VOICES*DIV_W-1:0] divider = '0;
   logic [VOICES*2-1:0]     mode = '0;
   logic [VOICES-1:0]       gate = '0;
   logic                    strobe = 1'b0;
   logic [SW-1:0]           sample;
   logic                    sample_valid, busy, pwm_output;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int m_phase [VOICES];
   int m_cnt = 0;
   int m_ticks = 0;
   int m_tick_cyc = 0;
   int m_exp = 0;

   poly_sound_driver #(.VOICES(VOICES), .DIV_W(DIV_W), .SAMPLE_W(SW), .SAMPLE_DIV(SDIV)) dut (
      .clk(clk), .nrst(nrst), .divider(divider), .mode(mode), .gate(gate), .strobe(strobe),
      .sample(sample), .sample_valid(sample_valid), .busy(busy), .pwm_output(pwm_output)
   );

   always #5 clk = ~clk;

   // Expected mix from the current phases and inputs, using plain integer arithmetic.
   function automatic int ref_sample();
      int acc = 0;
      for (int v = 0; v < VOICES; v++) begin
         longint d;
         int p, md, q, w, t;
         d  = longint'(divider[v*DIV_W +: DIV_W]);
         p  = m_phase[v];
         md = int'(mode[v*2 +: 2]);
         if (d == 0 || gate[v] == 1'b0 || md == 3) begin
            w = 0;
         end else begin
            if (p >= d) p = int'(d - 1);
            q = int'((longint'(p) * 256) / d);
            if (md == 0)      w = (q < 128) ? 255 : 0;
            else if (md == 1) w = q;
            else begin
               t = (q >= 128) ? 255 - q : q;
               w = (2 * t) % 256;
            end
         end
         acc += w;
      end
      return acc / VOICES;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!nrst) begin
         m_cnt <= 0;
         for (int v = 0; v < VOICES; v++) m_phase[v] <= 0;
      end else begin
         if (m_cnt == SDIV - 1) begin
            m_exp      <= ref_sample();
            m_ticks    <= m_ticks + 1;
            m_tick_cyc <= cyc;
         end
         m_cnt <= (m_cnt == SDIV - 1) ? 0 : m_cnt + 1;
         for (int v = 0; v < VOICES; v++) begin
            int d;
            d = int'(divider[v*DIV_W +: DIV_W]);
            if (d == 0 || m_phase[v] >= d - 1) m_phase[v] <= 0;
            else m_phase[v] <= m_phase[v] + 1;
         end
      end
   end

   task automatic set_voice(input int v, input int d, input int md, input bit g);
      divider[v*DIV_W +: DIV_W] = DIV_W'(d);
      mode[v*2 +: 2]            = 2'(md);
      gate[v]                   = g;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (sample_valid) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_cnt(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (m_cnt == n) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic count_pwm(output int hi);
      hi = 0;
      repeat (256) begin
         @(negedge clk);
         hi += int'(pwm_output);
      end
   endtask

   task automatic test_reset();
      bit ok;
      int t1, hi;
      nrst = 1'b0;
      strobe = 1'b1;
      for (int v = 0; v < VOICES; v++) set_voice(v, $urandom_range(1, 262143), $urandom_range(0, 3), 1'b0);
      repeat (10) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", busy); end
      checks++; if (sample !== 8'd0) begin errors++; $display("FAIL reset_sample: got %0d expected 0", sample); end
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", sample_valid); end
      checks++; if (pwm_output !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %0d expected 0", pwm_output); end
      nrst = 1'b1;
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL reset_first_valid: got timeout expected pulse"); end
      checks++; if (sample !== 8'd0) begin errors++; $display("FAIL gated_sample: got %0d expected 0", sample); end
      t1 = cyc;
      wait_valid(ok);
      checks++; if (cyc - t1 != SDIV) begin errors++; $display("FAIL valid_period: got %0d expected %0d", cyc - t1, SDIV); end
      count_pwm(hi);
      checks++; if (hi != 0) begin errors++; $display("FAIL silent_pwm: got %0d expected 0", hi); end
   endtask

   task automatic test_saw();
      bit ok;
      for (int v = 0; v < VOICES; v++) set_voice(v, 0, 1, v == 0);
      wait_valid(ok);
      wait_cnt(11, ok);
      checks++; if (!ok) begin errors++; $display("FAIL saw_align: got timeout expected count 11"); end
      set_voice(0, 1000, 1, 1'b1);
      wait_valid(ok);
      checks++; if (ok !== 1'b1 || int'(sample) != m_exp) begin errors++; $display("FAIL saw_first: got %0d expected %0d", sample, m_exp); end
      wait_valid(ok);
      checks++; if (ok !== 1'b1 || sample !== 8'd32) begin errors++; $display("FAIL saw_phase500: got %0d expected 32", sample); end
      for (int r = 0; r < 4; r++) begin
         set_voice(0, $urandom_range(1, 262143), 1, 1'b1);
         wait_valid(ok);
         checks++; if (ok !== 1'b1 || int'(sample) != m_exp) begin errors++; $display("FAIL saw_random: got %0d expected %0d", sample, m_exp); end
      end
   endtask

   task automatic test_square();
      bit ok;
      int zv;
      for (int v = 0; v < VOICES; v++) set_voice(v, 0, 0, 1'b1);
      wait_valid(ok);
      wait_cnt(100, ok);
      for (int v = 0; v < VOICES; v++) set_voice(v, $urandom_range(2000, 262143), 0, 1'b1);
      wait_valid(ok);
      checks++; if (ok !== 1'b1 || sample !== 8'd255) begin errors++; $display("FAIL square_all: got %0d expected 255", sample); end
      zv = $urandom_range(0, VOICES - 1);
      set_voice(zv, 0, 0, 1'b1);
      wait_valid(ok);
      checks++; if (ok !== 1'b1 || sample !== 8'd191) begin errors++; $display("FAIL square_one_silent: got %0d expected 191", sample); end
      checks++; if (int'(sample) != m_exp) begin errors++; $display("FAIL square_model: got %0d expected %0d", sample, m_exp); end
   endtask

   task automatic test_pwm();
      bit ok;
      int hi;
      for (int v = 0; v < VOICES; v++) set_voice(v, 0, 0, 1'b0);
      @(negedge clk);
      set_voice(0, 200000, 0, 1'b1);
      strobe = 1'b1;
      wait_valid(ok);
      checks++; if (ok !== 1'b1 || sample !== 8'd63) begin errors++; $display("FAIL pwm_sample63: got %0d expected 63", sample); end
      repeat (300) @(negedge clk);
      count_pwm(hi);
      checks++; if (hi != 63) begin errors++; $display("FAIL pwm_duty63: got %0d expected 63", hi); end
      strobe = 1'b0;
      set_voice(1, 200000, 0, 1'b1);
      set_voice(2, 200000, 0, 1'b1);
      wait_valid(ok);
      checks++; if (ok !== 1'b1 || sample !== 8'd191) begin errors++; $display("FAIL pwm_sample191: got %0d expected 191", sample); end
      repeat (300) @(negedge clk);
      count_pwm(hi);
      checks++; if (hi != 63) begin errors++; $display("FAIL pwm_duty_hold: got %0d expected 63", hi); end
      strobe = 1'b1;
      set_voice(3, 200000, 0, 1'b1);
      wait_valid(ok);
      repeat (300) @(negedge clk);
      count_pwm(hi);
      checks++; if (hi != 255) begin errors++; $display("FAIL pwm_duty255: got %0d expected 255", hi); end
   endtask

   task automatic test_triangle();
      bit ok;
      for (int v = 0; v < VOICES; v++) set_voice(v, 0, 2, v == 0);
      wait_valid(ok);
      wait_cnt(17, ok);
      checks++; if (!ok) begin errors++; $display("FAIL tri_align: got timeout expected count 17"); end
      set_voice(0, 1000, 2, 1'b1);
      for (int k = 0; k < 2; k++) begin
         wait_valid(ok);
         checks++; if (ok !== 1'b1 || int'(sample) != m_exp) begin errors++; $display("FAIL tri_model: got %0d expected %0d", sample, m_exp); end
      end
      wait_valid(ok);
      checks++; if (ok !== 1'b1 || sample !== 8'd31) begin errors++; $display("FAIL tri_q192: got %0d expected 31", sample); end
      set_voice(0, $urandom_range(1, 262143), 3, 1'b1);
      wait_valid(ok);
      checks++; if (ok !== 1'b1 || sample !== 8'd0) begin errors++; $display("FAIL mode_off: got %0d expected 0", sample); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int t, nv, nz;
      for (int v = 0; v < VOICES; v++) set_voice(v, $urandom_range(2000, 262143), 1, 1'b1);
      t = m_ticks;
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge clk);
         ok = (m_ticks != t);
      end
      checks++; if (!ok) begin errors++; $display("FAIL mid_tick: got timeout expected tick"); end
      repeat (24) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %0d expected 1", busy); end
      nrst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || sample !== 8'd0 || sample_valid !== 1'b0) begin
         errors++; $display("FAIL mid_reset_outputs: got busy=%0d sample=%0d valid=%0d expected 0 0 0", busy, sample, sample_valid); end
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      nv = 0; nz = 0;
      repeat (200) begin
         @(negedge clk);
         nv += int'(sample_valid);
         nz += (sample != 0) ? 1 : 0;
      end
      checks++; if (nv != 0 || nz != 0) begin errors++; $display("FAIL mid_quiet: got valids=%0d nonzero=%0d expected 0 0", nv, nz); end
      wait_valid(ok);
      checks++; if (ok !== 1'b1 || int'(sample) != m_exp) begin errors++; $display("FAIL mid_recover: got %0d expected %0d", sample, m_exp); end
   endtask

   task automatic test_phase_shrink();
      set_voice(0, 0, 1, 1'b1);
      repeat (2) @(negedge clk);
      set_voice(0, 1000, 1, 1'b1);
      repeat (700) @(negedge clk);
      checks++; if (dut.phase_q[0] !== 18'd700) begin errors++; $display("FAIL phase_700: got %0d expected 700", dut.phase_q[0]); end
      set_voice(0, 100, 1, 1'b1);
      @(negedge clk);
      checks++; if (dut.phase_q[0] !== 18'd0) begin errors++; $display("FAIL shrink_wrap: got %0d expected 0", dut.phase_q[0]); end
      @(negedge clk);
      checks++; if (dut.phase_q[0] !== 18'd1) begin errors++; $display("FAIL shrink_next: got %0d expected 1", dut.phase_q[0]); end
   endtask

   task automatic test_random();
      bit ok;
      int lat;
      wait_valid(ok);
      for (int r = 0; r < 8; r++) begin
         for (int v = 0; v < VOICES; v++)
            set_voice(v, ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 262143),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         wait_valid(ok);
         lat = cyc - m_tick_cyc - 1;
         checks++; if (ok !== 1'b1 || int'(sample) != m_exp) begin errors++; $display("FAIL random_sample: got %0d expected %0d", sample, m_exp); end
         checks++; if (lat < 1 || lat > MAXLAT) begin errors++; $display("FAIL random_latency: got %0d expected at most %0d", lat, MAXLAT); end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_saw();
      test_square();
      test_pwm();
      test_triangle();
      test_reset_mid();
      test_phase_shrink();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
